// File: rtl/pattern_source.sv
// Burst/gap AXI-Stream test-pattern source: fixed word, counter, Galois LFSR or
// walking-one, with a deferred link-reset that only lands on a word boundary.
module pattern_source #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = 32'h80200003
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] fixed_word,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [15:0]           burst_len,
  input  logic [15:0]           gap_len,
  input  logic                  fc_linkReset,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic                  tvalid_out,
  input  logic                  tready_out,
  output logic [31:0]           words_sent
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] WORD_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [DATA_WIDTH-1:0] lfsr_init(input logic [DATA_WIDTH-1:0] s);
    lfsr_init = (s == WORD_ZERO) ? WORD_ONE : s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] x);
    lfsr_step = (x >> 1) ^ (x[0] ? LFSR_POLY : WORD_ZERO);
  endfunction

  logic [1:0]            state_r;
  logic                  valid_r;
  logic [15:0]           burst_cnt_r;
  logic [15:0]           gap_cnt_r;
  logic [15:0]           burst_len_r;
  logic [15:0]           gap_len_r;
  logic [1:0]            mode_q_r;
  logic [DATA_WIDTH-1:0] cnt_r;
  logic [DATA_WIDTH-1:0] lfsr_r;
  logic [DATA_WIDTH-1:0] walk_r;
  logic                  pend_r;
  logic [31:0]           words_r;

  logic                  hs_s;
  logic                  pend_eff_s;
  logic                  apply_s;
  logic [1:0]            fsm_state_s;
  logic [15:0]           fsm_burst_s;
  logic [15:0]           fsm_gap_s;
  logic                  fsm_load_s;
  logic [1:0]            state_nx_s;
  logic                  load_s;

  assign hs_s       = tvalid_out & tready_out;
  // A pulse arriving on a boundary cycle applies at once so it can beat a burst end.
  assign pend_eff_s = pend_r | fc_linkReset;
  assign apply_s    = pend_eff_s & (~tvalid_out | hs_s);
  assign state_nx_s = apply_s ? (enable ? ST_BURST : ST_IDLE) : fsm_state_s;
  assign load_s     = apply_s ? enable : fsm_load_s;

  // Burst/gap sequencing before link-reset override.
  always_comb begin
    fsm_state_s = state_r;
    fsm_burst_s = burst_cnt_r;
    fsm_gap_s   = gap_cnt_r;
    fsm_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          fsm_state_s = ST_BURST;
          fsm_load_s  = 1'b1;
        end else begin
          fsm_state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (hs_s) begin
          if (!enable) begin
            fsm_state_s = ST_IDLE;
          end else if (burst_len_r == 16'd0) begin
            fsm_state_s = ST_BURST;
          end else if (burst_cnt_r == 16'd1) begin
            if (gap_len_r == 16'd0) begin
              fsm_state_s = ST_BURST;
              fsm_load_s  = 1'b1;
            end else begin
              fsm_state_s = ST_GAP;
              fsm_gap_s   = gap_len_r;
            end
          end else begin
            fsm_burst_s = burst_cnt_r - 16'd1;
          end
        end else begin
          fsm_state_s = ST_BURST;
        end
      end
      ST_GAP: begin
        if (!enable) begin
          fsm_state_s = ST_IDLE;
        end else if (gap_cnt_r == 16'd1) begin
          fsm_state_s = ST_BURST;
          fsm_load_s  = 1'b1;
        end else begin
          fsm_gap_s = gap_cnt_r - 16'd1;
        end
      end
      default: begin
        fsm_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM, latched configuration and handshake counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      valid_r     <= 1'b0;
      burst_cnt_r <= 16'd0;
      gap_cnt_r   <= 16'd0;
      burst_len_r <= 16'd0;
      gap_len_r   <= 16'd0;
      mode_q_r    <= 2'd0;
      pend_r      <= 1'b0;
      words_r     <= 32'd0;
    end else begin
      state_r   <= state_nx_s;
      valid_r   <= (state_nx_s == ST_BURST);
      gap_cnt_r <= fsm_gap_s;
      pend_r    <= apply_s ? 1'b0 : pend_eff_s;
      if (load_s) begin
        burst_cnt_r <= burst_len;
        burst_len_r <= burst_len;
        gap_len_r   <= gap_len;
        mode_q_r    <= mode;
      end else begin
        burst_cnt_r <= fsm_burst_s;
      end
      if (hs_s && (words_r != 32'hFFFF_FFFF)) begin
        words_r <= words_r + 32'd1;
      end else begin
        words_r <= words_r;
      end
    end
  end

  // Pattern generators: all advance on every handshake, link-reset reinitialises.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= WORD_ZERO;
      lfsr_r <= lfsr_init(seed);
      walk_r <= WORD_ONE;
    end else if (apply_s) begin
      cnt_r  <= WORD_ZERO;
      lfsr_r <= lfsr_init(seed);
      walk_r <= WORD_ONE;
    end else if (hs_s) begin
      cnt_r  <= cnt_r + WORD_ONE;
      lfsr_r <= lfsr_step(lfsr_r);
      walk_r <= {walk_r[DATA_WIDTH-2:0], walk_r[DATA_WIDTH-1]};
    end else begin
      cnt_r  <= cnt_r;
      lfsr_r <= lfsr_r;
      walk_r <= walk_r;
    end
  end

  // Output word is a zero-latency select of the generator registers.
  always_comb begin
    tdata_out = cnt_r;
    case (mode_q_r)
      2'd0:    tdata_out = fixed_word;
      2'd1:    tdata_out = cnt_r;
      2'd2:    tdata_out = lfsr_r;
      2'd3:    tdata_out = walk_r;
      default: tdata_out = cnt_r;
    endcase
  end

  assign tvalid_out = valid_r;
  assign words_sent = words_r;

endmodule

// File: tb/tb_pattern_source.sv
// Scoreboard bench for pattern_source: expected words queued with stimulus and
// popped on every observed handshake; direct checks for stalls and FSM timing.
module tb_pattern_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] fixed_word;
  logic [31:0] seed;
  logic [15:0] burst_len;
  logic [15:0] gap_len;
  logic        fc_linkReset;
  logic [31:0] tdata_out;
  logic        tvalid_out;
  logic        tready_out;
  logic [31:0] words_sent;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb_q[$];

  pattern_source dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .fixed_word(fixed_word), .seed(seed), .burst_len(burst_len), .gap_len(gap_len),
    .fc_linkReset(fc_linkReset), .tdata_out(tdata_out), .tvalid_out(tvalid_out),
    .tready_out(tready_out), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] x);
    lfsr_nx = (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h00000000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && tvalid_out && tready_out) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", sb_q.size(), 32'd1);
      end else begin
        check_val("hs_data", tdata_out, sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    check_val("sb_left", sb_q.size(), 32'd0);
    sb_q.delete();
    reset = 1'b1;
    enable = 1'b0;
    fc_linkReset = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_valid", {31'd0, tvalid_out}, 32'd0);
    check_val("rst_words", words_sent, 32'd0);
    tick();
  endtask

  initial begin
    logic [7:0]  pat;
    logic [31:0] lf;
    reset = 1'b1; enable = 1'b0; mode = 2'd1; fixed_word = 32'h0;
    seed = 32'h0; burst_len = 16'd0; gap_len = 16'd0; fc_linkReset = 1'b0;
    tready_out = 1'b1;

    // Continuous counter, five words
    do_reset();
    for (int i = 0; i < 5; i++) sb_q.push_back(i);
    enable = 1'b1;
    tick();
    repeat (5) tick();
    tready_out = 1'b0;
    @(negedge clk);
    check_val("cont_words", words_sent, 32'd5);
    check_val("cont_stall_data", tdata_out, 32'd5);

    // Burst 3 / gap 2 valid pattern
    mode = 2'd1; burst_len = 16'd3; gap_len = 16'd2;
    do_reset();
    tready_out = 1'b1;
    for (int i = 0; i < 6; i++) sb_q.push_back(i);
    pat = 8'b11100111;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val($sformatf("burst_valid_%0d", i), {31'd0, tvalid_out}, {31'd0, pat[7-i]});
      tick();
    end
    tready_out = 1'b0;
    @(negedge clk);
    check_val("burst_words", words_sent, 32'd6);

    // LFSR from zero seed
    mode = 2'd2; seed = 32'h0; burst_len = 16'd0; gap_len = 16'd0;
    do_reset();
    lf = 32'd1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(lf);
      lf = lfsr_nx(lf);
    end
    tready_out = 1'b1;
    enable = 1'b1;
    tick();
    repeat (3) tick();
    tready_out = 1'b0;
    @(negedge clk);
    check_val("lfsr_4th", tdata_out, lf);

    // Fixed word
    mode = 2'd0; fixed_word = 32'hDEADBEEF;
    do_reset();
    sb_q.push_back(32'hDEADBEEF);
    sb_q.push_back(32'hDEADBEEF);
    tready_out = 1'b1;
    enable = 1'b1;
    tick();
    repeat (2) tick();
    tready_out = 1'b0;

    // Walking one with stalls
    mode = 2'd3;
    do_reset();
    sb_q.push_back(32'd1);
    sb_q.push_back(32'd2);
    tready_out = 1'b1;
    enable = 1'b1;
    tick();
    tick();
    tready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("walk_hold_data", tdata_out, 32'd2);
      check_val("walk_hold_valid", {31'd0, tvalid_out}, 32'd1);
      tick();
    end
    tready_out = 1'b1;
    tick();
    tready_out = 1'b0;
    @(negedge clk);
    check_val("walk_next", tdata_out, 32'd4);

    // Link reset during a stall after ten words
    mode = 2'd1;
    do_reset();
    for (int i = 0; i < 10; i++) sb_q.push_back(i);
    tready_out = 1'b1;
    enable = 1'b1;
    tick();
    repeat (10) tick();
    tready_out = 1'b0;
    fc_linkReset = 1'b1;
    @(negedge clk);
    check_val("lr_hold_a", tdata_out, 32'd10);
    tick();
    fc_linkReset = 1'b0;
    @(negedge clk);
    check_val("lr_hold_b", tdata_out, 32'd10);
    check_val("lr_hold_valid", {31'd0, tvalid_out}, 32'd1);
    sb_q.push_back(32'd10);
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd1);
    tready_out = 1'b1;
    repeat (3) tick();
    tready_out = 1'b0;
    @(negedge clk);
    check_val("lr_words", words_sent, 32'd13);
    check_val("lr_after", tdata_out, 32'd2);

    // Enable dropped while stalled
    do_reset();
    tready_out = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("en_hold_data", tdata_out, 32'd0);
      check_val("en_hold_valid", {31'd0, tvalid_out}, 32'd1);
      tick();
    end
    sb_q.push_back(32'd0);
    tready_out = 1'b1;
    tick();
    @(negedge clk);
    check_val("en_idle_a", {31'd0, tvalid_out}, 32'd0);
    tick();
    @(negedge clk);
    check_val("en_idle_b", {31'd0, tvalid_out}, 32'd0);
    check_val("en_words", words_sent, 32'd1);

    // Link reset while idle restarts the counter
    fc_linkReset = 1'b1;
    tick();
    fc_linkReset = 1'b0;
    sb_q.push_back(32'd0);
    enable = 1'b1;
    tick();
    tick();
    tready_out = 1'b0;
    @(negedge clk);
    check_val("idle_lr_next", tdata_out, 32'd1);

    // Link reset coinciding with burst end beats the gap
    burst_len = 16'd3; gap_len = 16'd2;
    do_reset();
    tready_out = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(i);
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd1);
    enable = 1'b1;
    tick();
    tick();
    tick();
    fc_linkReset = 1'b1;
    tick();
    fc_linkReset = 1'b0;
    @(negedge clk);
    check_val("prio_valid", {31'd0, tvalid_out}, 32'd1);
    tick();
    tick();
    tready_out = 1'b0;
    @(negedge clk);
    check_val("prio_words", words_sent, 32'd5);
    check_val("sb_final", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
